// File: rtl/smpl_cnt_chk.sv
// Per-triangle fragment-count checker: sums per-lane hit pulses, closes a triangle on tri_done,
// and compares the total against the head of an expected-count FIFO.
module smpl_cnt_chk #(
  parameter int LANES     = 4,
  parameter int CNT_W     = 16,
  parameter int EXP_DEPTH = 8,
  parameter int TOL       = 0,
  parameter int ERR_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           exp_valid,
  input  logic [CNT_W-1:0]               exp_cnt,
  output logic                           exp_ready,
  input  logic [LANES-1:0]               hit_valid,
  input  logic                           tri_done,
  output logic                           chk_valid,
  output logic                           chk_pass,
  output logic [CNT_W-1:0]               chk_got,
  output logic [CNT_W-1:0]               chk_exp,
  output logic [$clog2(EXP_DEPTH+1)-1:0] fifo_level,
  output logic [31:0]                    tri_cnt,
  output logic [ERR_W-1:0]               err_cnt,
  output logic                           ovf_sticky,
  output logic                           unf_sticky,
  output logic                           sat_sticky,
  output logic                           fsm_state
);

  localparam int AW = $clog2(EXP_DEPTH);
  localparam int IW = $clog2(LANES + 1);
  localparam int SW = CNT_W + 1;

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  // Handshake: an expected count is taken on a clock edge where exp_valid && exp_ready;
  // a push offered while exp_ready is low is dropped and flagged in ovf_sticky.
  logic [CNT_W-1:0] mem [EXP_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] head;

  logic [CNT_W-1:0] cnt;
  logic [IW-1:0]    inc;
  logic [SW-1:0]    sum_w;
  logic             sum_sat;
  logic [CNT_W-1:0] sum_c;
  logic [SW-1:0]    got_w;
  logic [SW-1:0]    exp_w;
  logic [SW-1:0]    diff;
  logic             pass_now;
  state_t           state;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A closing triangle frees the head slot in the same cycle, so a full FIFO can still accept.
  assign exp_ready = !full || tri_done;
  assign push      = exp_valid && exp_ready;
  assign pop       = tri_done && !empty;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;

  always_comb begin
    inc = '0;
    for (int i = 0; i < LANES; i++) begin
      inc = inc + IW'(hit_valid[i]);
    end
  end

  assign sum_w   = {1'b0, cnt} + SW'(inc);
  assign sum_sat = sum_w[CNT_W];
  assign sum_c   = sum_sat ? '1 : sum_w[CNT_W-1:0];

  assign got_w    = {1'b0, sum_c};
  assign exp_w    = empty ? '0 : {1'b0, head};
  assign diff     = (got_w >= exp_w) ? (got_w - exp_w) : (exp_w - got_w);
  assign pass_now = !empty && (diff <= SW'(TOL));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= exp_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tri_done) begin
      cnt <= '0;
    end else begin
      cnt <= sum_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if ((|hit_valid) && !tri_done) state <= S_ACCUM;
        S_ACCUM: if (tri_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fsm_state = (state == S_ACCUM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      chk_valid  <= 1'b0;
      chk_pass   <= 1'b0;
      chk_got    <= '0;
      chk_exp    <= '0;
      tri_cnt    <= '0;
      err_cnt    <= '0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
      sat_sticky <= 1'b0;
    end else begin
      chk_valid <= tri_done;
      if (sum_sat) sat_sticky <= 1'b1;
      if (exp_valid && !exp_ready) ovf_sticky <= 1'b1;
      if (tri_done) begin
        chk_got  <= sum_c;
        chk_exp  <= exp_w[CNT_W-1:0];
        chk_pass <= pass_now;
        tri_cnt  <= tri_cnt + 32'd1;
        if (empty) unf_sticky <= 1'b1;
        if (!pass_now && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_smpl_cnt_chk.sv
// Bench for smpl_cnt_chk: directed scenarios and randomized traffic against a queue-based model,
// plus a narrow-counter instance for saturation and mid-triangle reset.
module tb_smpl_cnt_chk;
  localparam int D    = 8;
  localparam int TOL  = 0;
  localparam int MAXC = 65535;
  localparam int MAXE = 65535;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        exp_valid;
  logic [15:0] exp_cnt;
  logic        exp_ready;
  logic [3:0]  hit_valid;
  logic        tri_done;
  logic        chk_valid, chk_pass;
  logic [15:0] chk_got, chk_exp;
  logic [3:0]  fifo_level;
  logic [31:0] tri_cnt;
  logic [15:0] err_cnt;
  logic        ovf_sticky, unf_sticky, sat_sticky, fsm_state;

  smpl_cnt_chk #(.LANES(4), .CNT_W(16), .EXP_DEPTH(D), .TOL(TOL), .ERR_W(16)) u_dut (
    .clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_cnt(exp_cnt), .exp_ready(exp_ready),
    .hit_valid(hit_valid), .tri_done(tri_done), .chk_valid(chk_valid), .chk_pass(chk_pass),
    .chk_got(chk_got), .chk_exp(chk_exp), .fifo_level(fifo_level), .tri_cnt(tri_cnt),
    .err_cnt(err_cnt), .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky),
    .sat_sticky(sat_sticky), .fsm_state(fsm_state)
  );

  logic        s_rst, s_exp_valid, s_exp_ready, s_tri_done;
  logic [3:0]  s_exp_cnt, s_hit_valid, s_chk_got, s_chk_exp, s_fifo_level;
  logic        s_chk_valid, s_chk_pass, s_ovf, s_unf, s_sat, s_fsm;
  logic [31:0] s_tri_cnt;
  logic [15:0] s_err_cnt;

  smpl_cnt_chk #(.LANES(4), .CNT_W(4), .EXP_DEPTH(D), .TOL(0), .ERR_W(16)) u_small (
    .clk(clk), .rst(s_rst), .exp_valid(s_exp_valid), .exp_cnt(s_exp_cnt),
    .exp_ready(s_exp_ready), .hit_valid(s_hit_valid), .tri_done(s_tri_done),
    .chk_valid(s_chk_valid), .chk_pass(s_chk_pass), .chk_got(s_chk_got), .chk_exp(s_chk_exp),
    .fifo_level(s_fifo_level), .tri_cnt(s_tri_cnt), .err_cnt(s_err_cnt), .ovf_sticky(s_ovf),
    .unf_sticky(s_unf), .sat_sticky(s_sat), .fsm_state(s_fsm)
  );

  // scoreboard / reference model
  logic [15:0] exp_q[$];
  int          m_cnt, m_got, m_exp, m_err;
  logic        m_valid, m_pass, m_ovf, m_unf, m_sat;
  logic [31:0] m_tri;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0; m_got = 0; m_exp = 0; m_err = 0; m_tri = '0;
    m_valid = 0; m_pass = 0; m_ovf = 0; m_unf = 0; m_sat = 0;
  endtask

  task automatic check_outputs();
    check("chk_valid", chk_valid, m_valid);
    check("chk_pass", chk_pass, m_pass);
    check("chk_got", chk_got, m_got);
    check("chk_exp", chk_exp, m_exp);
    check("fifo_level", fifo_level, exp_q.size());
    check("tri_cnt", tri_cnt, m_tri);
    check("err_cnt", err_cnt, m_err);
    check("ovf_sticky", ovf_sticky, m_ovf);
    check("unf_sticky", unf_sticky, m_unf);
    check("sat_sticky", sat_sticky, m_sat);
    check("fsm_state", fsm_state, m_cnt != 0);
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b0; exp_valid = 1'b0; exp_cnt = '0; hit_valid = '0; tri_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    check("rst_exp_ready", exp_ready, 1);
    rst = 1'b1;
  endtask

  task automatic cycle(input logic ev, input logic [15:0] ec, input logic [3:0] hv,
                       input logic td);
    logic acc, had;
    int   sum, e, d;
    exp_valid = ev; exp_cnt = ec; hit_valid = hv; tri_done = td;
    #1;
    check("exp_ready", exp_ready, (exp_q.size() < D) || td);
    acc = ev && ((exp_q.size() < D) || td);
    if (ev && !acc) m_ovf = 1;
    sum = m_cnt + $countones(hv);
    if (sum > MAXC) begin
      sum = MAXC;
      m_sat = 1;
    end
    m_valid = td;
    if (td) begin
      had = exp_q.size() > 0;
      e = had ? int'(exp_q.pop_front()) : 0;
      d = (sum > e) ? sum - e : e - sum;
      m_got = sum; m_exp = e;
      m_pass = had && (d <= TOL);
      if (!had) m_unf = 1;
      m_tri = m_tri + 1;
      if (!m_pass && m_err < MAXE) m_err++;
      m_cnt = 0;
    end else begin
      m_cnt = sum;
    end
    if (acc) exp_q.push_back(ec);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic s_step(input logic r, input logic [3:0] hv, input logic td);
    s_rst = r; s_hit_valid = hv; s_tri_done = td;
    @(posedge clk);
    #1;
  endtask

  initial begin
    s_rst = 1'b0; s_exp_valid = 1'b0; s_exp_cnt = '0; s_hit_valid = '0; s_tri_done = 1'b0;

    do_reset();

    cycle(1, 16'd5, 4'b0000, 0);
    cycle(0, 16'd0, 4'b0111, 0);
    cycle(0, 16'd0, 4'b0011, 1);
    check("t2_valid", chk_valid, 1);
    check("t2_got", chk_got, 5);
    check("t2_pass", chk_pass, 1);
    check("t2_err", err_cnt, 0);

    do_reset();
    cycle(1, 16'd3, 4'b0000, 0);
    cycle(1, 16'd7, 4'b0000, 0);
    cycle(0, 16'd0, 4'b0111, 1);
    check("t3_pass1", chk_pass, 1);
    cycle(0, 16'd0, 4'b1111, 0);
    cycle(0, 16'd0, 4'b0011, 1);
    check("t3_pass2", chk_pass, 0);
    check("t3_got2", chk_got, 6);
    check("t3_err", err_cnt, 1);
    check("t3_tri", tri_cnt, 2);

    cycle(1, 16'd2, 4'b0000, 1);
    check("t4_unf", unf_sticky, 1);
    check("t4_pass", chk_pass, 0);
    check("t4_exp", chk_exp, 0);
    check("t4_level", fifo_level, 1);

    for (int i = 0; i < 7; i++) cycle(1, 16'($urandom_range(1, 20)), 4'b0000, 0);
    check("t5_full", fifo_level, 8);
    cycle(1, 16'd9, 4'b0000, 0);
    check("t5_ovf", ovf_sticky, 1);
    check("t5_level_drop", fifo_level, 8);
    cycle(1, 16'd11, 4'b0001, 1);
    check("t5_level_swap", fifo_level, 8);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle(1'($urandom_range(0, 1)), 16'($urandom_range(0, 10)), 4'($urandom),
            $urandom_range(0, 3) == 0);
    end
    exp_valid = 1'b0; hit_valid = '0; tri_done = 1'b0;

    // narrow counter: saturation, then reset in the middle of a triangle
    s_step(1'b0, 4'b0000, 1'b0);
    s_step(1'b0, 4'b0000, 1'b0);
    check("s_rst_got", s_chk_got, 0);
    check("s_rst_ready", s_exp_ready, 1);
    for (int i = 0; i < 4; i++) s_step(1'b1, 4'b1111, 1'b0);
    s_step(1'b1, 4'b1111, 1'b1);
    check("s_sat_valid", s_chk_valid, 1);
    check("s_sat_got", s_chk_got, 15);
    check("s_sat_sticky", s_sat, 1);
    s_step(1'b1, 4'b0011, 1'b0);
    s_step(1'b1, 4'b1111, 1'b0);
    s_step(1'b0, 4'b0000, 1'b0);
    check("s_mid_rst_sat", s_sat, 0);
    s_step(1'b1, 4'b0011, 1'b1);
    check("s_after_rst_got", s_chk_got, 2);
    check("s_after_rst_exp", s_chk_exp, 0);
    check("s_after_rst_pass", s_chk_pass, 0);
    check("s_after_rst_unf", s_unf, 1);
    check("s_after_rst_tri", s_tri_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
